pixel_array_arbiter: RTL and testbench

//  Parametrised two-level (row, then column) round-robin arbiter for an ROWS x COLS event-pixel group.

---
 rtl/pixel_arb_pkg.sv | 17 +
 rtl/rr_arb_core.sv | 37 +++
 rtl/pixel_array_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_pixel_array_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arb_pkg.sv
// Shared types and defaults for the pixel-group arbiter and its round-robin core.
package pixel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROW_ARB = 2'd1,
        COL_ARB = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int POL_W_DEF = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational wrap-around priority search: first requester at or after ptr.
module rr_arb_core
    import pixel_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          valid,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Two passes: requesters at or above ptr first, then the wrapped-around lower half.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (valid && !any && req[j] && (IW'(j) >= ptr)) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (valid && !any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_array_arbiter.sv
// Two-level (row, then column) round-robin arbiter serialising the pixel events
// of one ROWS x COLS group onto a valid/ready address-event stream.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | nothing in flight; wait for enable_i and any request
//  ROW_ARB | pick next requesting row after row_ptr, reset col_ptr
//  COL_ARB | pick next requesting column of the latched row, latch event
//  HOLD    | event presented; wait for evt_ready_i, then pick next step
module pixel_array_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int POL_W = POL_W_DEF,
    parameter int XW    = $clog2(ROWS),
    parameter int YW    = $clog2(COLS)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 enable_i,
    input  logic [ROWS-1:0][COLS-1:0][POL_W-1:0] req_i,
    output logic [ROWS-1:0][COLS-1:0]            gnt_o,
    output logic                                 evt_valid_o,
    input  logic                                 evt_ready_i,
    output logic [XW-1:0]                        evt_x_o,
    output logic [YW-1:0]                        evt_y_o,
    output logic [POL_W-1:0]                     evt_pol_o,
    output logic                                 req_o,
    output logic                                 active_o,
    output logic                                 grp_release_o
);

    state_t                     state;
    logic [XW-1:0]              row_ptr;
    logic [YW-1:0]              col_ptr;
    logic [ROWS-1:0]            row_sel_q;
    logic [COLS-1:0]            col_sel_q;
    logic                       mask_q;
    logic                       hs;

    logic [ROWS-1:0][COLS-1:0]  req_nz;
    logic [ROWS-1:0][COLS-1:0]  req_m;
    logic [ROWS-1:0]            row_any;
    logic [COLS-1:0]            col_req;
    logic [COLS-1:0][POL_W-1:0] row_pol;
    logic [POL_W-1:0]           col_pol;
    logic                       cur_row_any;
    logic                       arr_any;

    logic [ROWS-1:0]            row_gnt;
    logic [XW-1:0]              row_idx;
    logic                       row_found;
    logic [COLS-1:0]            col_gnt;
    logic [YW-1:0]              col_idx;
    logic                       col_found;

    function automatic logic [XW-1:0] row_inc(input logic [XW-1:0] v);
        return (v == XW'(ROWS - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [YW-1:0] col_inc(input logic [YW-1:0] v);
        return (v == YW'(COLS - 1)) ? '0 : v + 1'b1;
    endfunction

    // The served pixel is hidden on the handshake cycle and the one after it,
    // giving it a cycle to drop its request after seeing gnt_o.
    always_comb begin
        hs    = (state == HOLD) && evt_valid_o && evt_ready_i;
        req_o = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                req_nz[r][c] = |req_i[r][c];
                req_o        = req_o | req_nz[r][c];
                gnt_o[r][c]  = hs && row_sel_q[r] && col_sel_q[c];
                req_m[r][c]  = req_nz[r][c] &&
                               !((hs || mask_q) && row_sel_q[r] && col_sel_q[c]);
            end
        end
    end

    always_comb begin
        col_req     = '0;
        row_pol     = '0;
        cur_row_any = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            row_any[r] = |req_m[r];
            if (row_sel_q[r]) begin
                col_req     = req_m[r];
                row_pol     = req_i[r];
                cur_row_any = |req_m[r];
            end
        end
        arr_any = |row_any;
    end

    always_comb begin
        col_pol = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_gnt[c]) begin
                col_pol = row_pol[c];
            end
        end
    end

    rr_arb_core #(.N(ROWS), .IW(XW)) u_row_arb (
        .req   (row_any),
        .ptr   (row_ptr),
        .valid (state == ROW_ARB),
        .gnt   (row_gnt),
        .idx   (row_idx),
        .any   (row_found)
    );

    rr_arb_core #(.N(COLS), .IW(YW)) u_col_arb (
        .req   (col_req),
        .ptr   (col_ptr),
        .valid (state == COL_ARB),
        .gnt   (col_gnt),
        .idx   (col_idx),
        .any   (col_found)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            row_ptr       <= '0;
            col_ptr       <= '0;
            row_sel_q     <= '0;
            col_sel_q     <= '0;
            mask_q        <= 1'b0;
            evt_valid_o   <= 1'b0;
            evt_x_o       <= '0;
            evt_y_o       <= '0;
            evt_pol_o     <= '0;
            active_o      <= 1'b0;
            grp_release_o <= 1'b0;
        end else begin
            grp_release_o <= 1'b0;
            mask_q        <= hs;
            case (state)
                IDLE: begin
                    if (enable_i && req_o) begin
                        state    <= ROW_ARB;
                        active_o <= 1'b1;
                    end
                end
                ROW_ARB: begin
                    if (!enable_i) begin
                        state    <= IDLE;
                        active_o <= 1'b0;
                        row_ptr  <= '0;
                        col_ptr  <= '0;
                    end else if (row_found) begin
                        state     <= COL_ARB;
                        evt_x_o   <= row_idx;
                        row_sel_q <= row_gnt;
                        row_ptr   <= row_inc(row_idx);
                        col_ptr   <= '0;
                    end else begin
                        state    <= IDLE;
                        active_o <= 1'b0;
                    end
                end
                COL_ARB: begin
                    if (!enable_i) begin
                        state    <= IDLE;
                        active_o <= 1'b0;
                        row_ptr  <= '0;
                        col_ptr  <= '0;
                    end else if (col_found) begin
                        state       <= HOLD;
                        evt_y_o     <= col_idx;
                        col_sel_q   <= col_gnt;
                        evt_pol_o   <= col_pol;
                        col_ptr     <= col_inc(col_idx);
                        evt_valid_o <= 1'b1;
                    end else begin
                        state <= ROW_ARB;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        evt_valid_o <= 1'b0;
                        if (!enable_i) begin
                            state    <= IDLE;
                            active_o <= 1'b0;
                            row_ptr  <= '0;
                            col_ptr  <= '0;
                        end else if (cur_row_any) begin
                            state <= COL_ARB;
                        end else if (arr_any) begin
                            state <= ROW_ARB;
                        end else begin
                            state         <= IDLE;
                            active_o      <= 1'b0;
                            grp_release_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_arbiter.sv
// Bench for pixel_array_arbiter: an 8x8 and a 3x5 instance checked against a
// static-request service-order model.
module tb_pixel_array_arbiter;

    typedef struct {
        int r;
        int c;
        int p;
    } ev_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b1;
    logic ready = 1'b1;
    logic sel   = 1'b0;
    logic [1:0] pend [8][8];

    int errors = 0;
    int checks = 0;
    int mptr8  = 0;
    int mptr35 = 0;
    ev_t exp_q[$];
    int  gnt_cyc[$];

    always #5 clk = ~clk;

    logic [7:0][7:0][1:0] req8;
    logic [7:0][7:0]      gnt8;
    logic                 v8, ro8, act8, rel8;
    logic [2:0]           x8, y8;
    logic [1:0]           p8;

    logic [2:0][4:0][1:0] req35;
    logic [2:0][4:0]      gnt35;
    logic                 v35, ro35, act35, rel35;
    logic [1:0]           x35;
    logic [2:0]           y35;
    logic [1:0]           p35;

    pixel_array_arbiter #(.ROWS(8), .COLS(8), .POL_W(2)) dut8 (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req8), .gnt_o(gnt8),
        .evt_valid_o(v8), .evt_ready_i(ready), .evt_x_o(x8), .evt_y_o(y8),
        .evt_pol_o(p8), .req_o(ro8), .active_o(act8), .grp_release_o(rel8)
    );

    pixel_array_arbiter #(.ROWS(3), .COLS(5), .POL_W(2)) dut35 (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req35), .gnt_o(gnt35),
        .evt_valid_o(v35), .evt_ready_i(ready), .evt_x_o(x35), .evt_y_o(y35),
        .evt_pol_o(p35), .req_o(ro35), .active_o(act35), .grp_release_o(rel35)
    );

    logic [7:0][7:0] obs_gnt;
    logic            obs_valid, obs_req, obs_act, obs_rel;
    int              obs_x, obs_y, obs_pol;

    always_comb begin
        req8  = '0;
        req35 = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (!sel) req8[r][c] = pend[r][c];
                else if (r < 3 && c < 5) req35[r][c] = pend[r][c];
            end
    end

    always_comb begin
        obs_gnt = '0;
        if (sel) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 5; c++) obs_gnt[r][c] = gnt35[r][c];
        end else begin
            obs_gnt = gnt8;
        end
        obs_valid = sel ? v35 : v8;
        obs_req   = sel ? ro35 : ro8;
        obs_act   = sel ? act35 : act8;
        obs_rel   = sel ? rel35 : rel8;
        obs_x     = sel ? int'(x35) : int'(x8);
        obs_y     = sel ? int'(y35) : int'(y8);
        obs_pol   = sel ? int'(p35) : int'(p8);
    end

    // Static requests that drop on grant: rows served in cyclic order from the
    // row pointer, each row's columns in ascending order.
    function automatic void build_exp(input int nr, input int nc, input int ptr);
        ev_t e;
        exp_q.delete();
        for (int k = 0; k < nr; k++) begin
            int r;
            r = (ptr + k) % nr;
            for (int c = 0; c < nc; c++) begin
                if (pend[r][c] != 2'b00) begin
                    e.r = r; e.c = c; e.p = int'(pend[r][c]);
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic clear_pend();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pend[r][c] = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; en = 1'b1; ready = 1'b1;
        clear_pend();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mptr8 = 0; mptr35 = 0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!obs_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!obs_valid) begin
            errors++;
            $display("FAIL %s wait_valid: evt_valid=%0b after %0d cycles, want 1", name, obs_valid, n);
        end
    endtask

    task automatic run_batch(input string name, input int nr, input int nc, inout int mptr, input bit stall);
        ev_t e;
        int cyc, budget, gc, rel_cnt, last_r;
        build_exp(nr, nc, mptr);
        if (exp_q.size() == 0) return;
        budget = 40 + 16 * exp_q.size();
        cyc = 0; rel_cnt = 0; last_r = mptr;
        gnt_cyc.delete();
        while (exp_q.size() != 0 && cyc < budget) begin
            @(negedge clk);
            ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1; cyc++;
            e  = exp_q[0];
            gc = $countones(obs_gnt);
            if (obs_rel) rel_cnt++;
            if (obs_valid) begin
                checks++;
                if (obs_x != e.r || obs_y != e.c || obs_pol != e.p || obs_x >= nr || obs_y >= nc) begin
                    errors++;
                    $display("FAIL %s evt: got (%0d,%0d,pol %0d) want (%0d,%0d,pol %0d)",
                             name, obs_x, obs_y, obs_pol, e.r, e.c, e.p);
                end
            end
            if (gc != 0 || (obs_valid && ready)) begin
                checks++;
                if (gc != 1 || !obs_gnt[e.r][e.c] || !ready || !obs_valid) begin
                    errors++;
                    $display("FAIL %s gnt: got %0d bits, bit(%0d,%0d)=%0b ready=%0b valid=%0b, want one bit at (%0d,%0d)",
                             name, gc, e.r, e.c, obs_gnt[e.r][e.c], ready, obs_valid, e.r, e.c);
                end
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        if (obs_gnt[r][c]) pend[r][c] = 2'b00;
                pend[e.r][e.c] = 2'b00;
                gnt_cyc.push_back(cyc);
                last_r = e.r;
                void'(exp_q.pop_front());
            end
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: %0d events left, want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (obs_rel) rel_cnt++;
        end
        checks++;
        if (rel_cnt != 1 || obs_act) begin
            errors++;
            $display("FAIL %s release: pulses=%0d active=%0b, want 1 and 0", name, rel_cnt, obs_act);
        end
        mptr = (last_r + 1) % nr;
    endtask

    task automatic test_reset();
        checks++;
        if (v8 || act8 || rel8 || gnt8 != '0 || x8 != 0 || y8 != 0 || p8 != 0 || ro8) begin
            errors++;
            $display("FAIL reset_state: valid=%0b act=%0b rel=%0b gnt=%h x=%0d y=%0d pol=%0d req=%0b, want all 0",
                     v8, act8, rel8, gnt8, x8, y8, p8, ro8);
        end
        pend[4][4] = 2'b10; #1;
        checks++;
        if (ro8 !== 1'b1) begin
            errors++; $display("FAIL req_o_comb: got %0b want 1", ro8);
        end
        pend[4][4] = 2'b00;
        do_reset();
        ready = 1'b0;
        pend[5][3] = 2'b01; pend[7][0] = 2'b11;
        wait_valid("reset_mid_hold");
        checks++;
        if (obs_x != 5 || obs_y != 3) begin
            errors++; $display("FAIL reset_hold_evt: got (%0d,%0d) want (5,3)", obs_x, obs_y);
        end
        pend[2][1] = 2'b10;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (obs_valid || obs_act || obs_rel || obs_gnt != '0 || obs_x != 0 || obs_y != 0 || obs_pol != 0 || !obs_req) begin
            errors++;
            $display("FAIL reset_async: valid=%0b act=%0b rel=%0b x=%0d y=%0d pol=%0d req=%0b, want 0s and req 1",
                     obs_valid, obs_act, obs_rel, obs_x, obs_y, obs_pol, obs_req);
        end
        @(negedge clk); rst = 1'b0; mptr8 = 0;
        run_batch("reset_release", 8, 8, mptr8, 1'b0);
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk); pend[2][5] = 2'b01;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        checks++;
        if (obs_valid) begin
            errors++; $display("FAIL single_early: valid=%0b after 2 edges, want 0", obs_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (!obs_valid || obs_x != 2 || obs_y != 5 || obs_pol != 1 || !obs_gnt[2][5] || $countones(obs_gnt) != 1) begin
            errors++;
            $display("FAIL single_evt: valid=%0b (%0d,%0d,pol %0d) gnt25=%0b, want 1 (2,5,pol 1) 1",
                     obs_valid, obs_x, obs_y, obs_pol, obs_gnt[2][5]);
        end
        pend[2][5] = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (obs_gnt != '0 || obs_valid || !obs_rel) begin
            errors++;
            $display("FAIL single_after: gnt=%0d bits valid=%0b rel=%0b, want 0 0 1", $countones(obs_gnt), obs_valid, obs_rel);
        end
        @(negedge clk); #1;
        checks++;
        if (obs_rel || obs_act) begin
            errors++; $display("FAIL single_pulse: rel=%0b act=%0b, want 0 0", obs_rel, obs_act);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pend[1][0] = 2'($urandom_range(1, 3));
        pend[1][3] = 2'($urandom_range(1, 3));
        pend[4][2] = 2'($urandom_range(1, 3));
        run_batch("b2b", 8, 8, mptr8, 1'b0);
        checks++;
        if (gnt_cyc.size() != 3 ? 1'b1 : (gnt_cyc[1] - gnt_cyc[0] != 2 || gnt_cyc[2] - gnt_cyc[1] != 3)) begin
            errors++;
            $display("FAIL b2b_timing: %0d grants, gaps %0d/%0d, want 3 grants gaps 2/3", gnt_cyc.size(),
                     gnt_cyc.size() == 3 ? gnt_cyc[1] - gnt_cyc[0] : -1,
                     gnt_cyc.size() == 3 ? gnt_cyc[2] - gnt_cyc[1] : -1);
        end
    endtask

    task automatic test_fairness();
        int k, cyc, rr, er, rel_seen;
        do_reset();
        pend[0][0] = 2'b01; pend[3][3] = 2'b01;
        k = 0; cyc = 0; rr = -1; rel_seen = 0;
        while (k < 20 && cyc < 200) begin
            @(negedge clk);
            if (rr >= 0) begin pend[rr][rr] = 2'b01; rr = -1; end
            #1; cyc++;
            if (obs_rel) rel_seen++;
            if ($countones(obs_gnt) != 0) begin
                er = (k % 2 == 0) ? 0 : 3;
                checks++;
                if (!obs_gnt[er][er] || $countones(obs_gnt) != 1) begin
                    errors++;
                    $display("FAIL fair_%0d: gnt(%0d,%0d)=%0b bits=%0d, want single grant on row %0d",
                             k, er, er, obs_gnt[er][er], $countones(obs_gnt), er);
                end
                pend[er][er] = 2'b00; rr = er; k++;
            end
        end
        checks++;
        if (k != 20 || rel_seen != 0) begin
            errors++; $display("FAIL fair_total: grants=%0d releases=%0d, want 20 and 0", k, rel_seen);
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b0;
        pend[6][1] = 2'b10;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (!obs_valid || obs_x != 6 || obs_y != 1 || obs_pol != 2 || obs_gnt != '0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%0b (%0d,%0d,pol %0d) gnt bits=%0d, want 1 (6,1,pol 2) 0",
                         i, obs_valid, obs_x, obs_y, obs_pol, $countones(obs_gnt));
            end
        end
        @(negedge clk); ready = 1'b1; #1;
        checks++;
        if (!obs_gnt[6][1] || $countones(obs_gnt) != 1) begin
            errors++; $display("FAIL stall_gnt: gnt61=%0b bits=%0d, want 1 1", obs_gnt[6][1], $countones(obs_gnt));
        end
        pend[6][1] = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (obs_gnt != '0 || obs_valid) begin
            errors++; $display("FAIL stall_pulse: gnt bits=%0d valid=%0b, want 0 0", $countones(obs_gnt), obs_valid);
        end
    endtask

    task automatic test_enable();
        do_reset();
        ready = 1'b0;
        pend[3][2] = 2'b01; pend[3][6] = 2'b11;
        wait_valid("enable");
        @(negedge clk); en = 1'b0; ready = 1'b1; #1;
        checks++;
        if (!obs_gnt[3][2] || $countones(obs_gnt) != 1 || obs_x != 3 || obs_y != 2) begin
            errors++;
            $display("FAIL en_hold_gnt: gnt32=%0b evt (%0d,%0d), want 1 (3,2)", obs_gnt[3][2], obs_x, obs_y);
        end
        pend[3][2] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs_gnt != '0 || obs_act || obs_valid || obs_rel) begin
                errors++;
                $display("FAIL en_off_%0d: gnt bits=%0d act=%0b valid=%0b rel=%0b, want all 0",
                         i, $countones(obs_gnt), obs_act, obs_valid, obs_rel);
            end
        end
        en = 1'b1; mptr8 = 0;
        run_batch("en_resume", 8, 8, mptr8, 1'b0);
    endtask

    task automatic fill_random(input int nr, input int nc, input int dens);
        int n;
        n = 0;
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                if ($urandom_range(0, dens) == 0) begin
                    pend[r][c] = 2'($urandom_range(1, 3)); n++;
                end
        if (n == 0) pend[$urandom_range(0, nr - 1)][$urandom_range(0, nc - 1)] = 2'b01;
    endtask

    task automatic test_random();
        for (int b = 0; b < 10; b++) begin
            fill_random(8, 8, 7);
            run_batch($sformatf("rand8_%0d", b), 8, 8, mptr8, 1'b1);
        end
    endtask

    task automatic test_small();
        do_reset();
        sel = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            pend[2][4] = 2'b11; pend[0][0] = 2'b01;
            run_batch($sformatf("small_pass%0d", pass), 3, 5, mptr35, 1'b0);
        end
        for (int b = 0; b < 8; b++) begin
            fill_random(3, 5, 2);
            run_batch($sformatf("rand35_%0d", b), 3, 5, mptr35, 1'b1);
        end
        sel = 1'b0;
    endtask

    initial begin
        clear_pend();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_stall();
        test_enable();
        test_random();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
